// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder
//   Responder side of the instruction-fetch interface. Holds a word-organised
//   instruction store (written via the loader port) and answers one fetch at a
//   time after LATENCY wait cycles, with a flush input that drops any
//   in-flight fetch.
//
// Ports
//   clk, rst            : clock (rising edge) / asynchronous active-low reset
//   req_valid/req_ready : fetch request handshake, req_addr = byte address (PC)
//   flush               : redirect; abandons the outstanding fetch
//   resp_valid/ready    : response handshake
//   resp_data/addr/err  : instruction word, its address, misalignment flag
//   ld_en/ld_addr/data  : loader write port (word index)
module imem_fetch_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  input  logic                  flush,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic                  resp_err,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-3:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // State entered on accept and initial wait count, both fixed by LATENCY.
  localparam state_t     ACC_STATE = (LATENCY == 0) ? RESP : WAIT;
  localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  err_q, err_d;
  logic                  accept;
  logic                  misaligned;

  // Store is not reset. The fetch path reads mem_q combinationally, so a
  // loader write on the accept edge is not seen by that fetch.
  always_ff @(posedge clk) begin
    if (ld_en) mem_q[ld_addr] <= ld_data;
  end

  assign req_ready  = !flush && (state_q == IDLE || (state_q == RESP && resp_ready));
  assign accept     = req_valid && req_ready;
  assign misaligned = |req_addr[1:0];
  assign resp_valid = (state_q == RESP);
  assign resp_data  = data_q;
  assign resp_addr  = addr_q;
  assign resp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    addr_d  = addr_q;
    err_d   = err_q;

    // accept is already gated off by flush via req_ready.
    if (accept) begin
      addr_d = req_addr;
      err_d  = misaligned;
      data_d = misaligned ? '0 : mem_q[req_addr[ADDR_WIDTH-1:2]];
    end

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = ACC_STATE;
            cnt_d   = WAIT_INIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) state_d = RESP;
          else               cnt_d   = cnt_q - 4'd1;
        end
        RESP: begin
          if (resp_ready) begin
            if (accept) begin
              state_d = ACC_STATE;
              cnt_d   = WAIT_INIT;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder. Three instances (LATENCY 2, 0, 3)
// share one set of inputs; each phase checks one instance, and a flush cycle
// between phases returns every instance to IDLE.
module tb_imem_fetch_responder;

  localparam logic [31:0] W0 = 32'h0000_0013;
  localparam logic [31:0] W1 = 32'h0050_0093;
  localparam logic [31:0] W2 = 32'h00A0_0113;
  localparam logic [31:0] W3 = 32'hDEAD_BEEF;
  localparam logic [31:0] WN = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, flush, resp_ready, ld_en;
  logic [7:0]  req_addr;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;

  logic        rdy2, val2, err2, rdy0, val0, err0, rdy3, val3, err3;
  logic [31:0] dat2, dat0, dat3;
  logic [7:0]  adr2, adr0, adr3;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imem_fetch_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(rdy2),
    .flush(flush), .resp_valid(val2), .resp_ready(resp_ready), .resp_data(dat2),
    .resp_addr(adr2), .resp_err(err2), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  imem_fetch_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(rdy0),
    .flush(flush), .resp_valid(val0), .resp_ready(resp_ready), .resp_data(dat0),
    .resp_addr(adr0), .resp_err(err0), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  imem_fetch_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(rdy3),
    .flush(flush), .resp_valid(val3), .resp_ready(resp_ready), .resp_data(dat3),
    .resp_addr(adr3), .resp_err(err3), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_idle();
    req_valid = 1'b0;
    flush     = 1'b1;
    step();
    flush     = 1'b0;
  endtask

  task automatic load(input logic [5:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    resp_ready = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    #1;
    chk("rst_valid", {31'd0, val2}, 32'd0);
    chk("rst_data",  dat2, 32'd0);
    chk("rst_addr",  {24'd0, adr2}, 32'd0);
    chk("rst_err",   {31'd0, err2}, 32'd0);
    chk("rst_ready", {31'd0, rdy2}, 32'd1);
    #11 rst = 1'b1;

    load(6'd0, W0); load(6'd1, W1); load(6'd2, W2); load(6'd3, W3);

    // Phase 1: LATENCY=2, fetch 0x08
    req_valid = 1'b1; req_addr = 8'h08;
    #1 chk("p1_ready", {31'd0, rdy2}, 32'd1);
    step();
    req_valid = 1'b0;
    chk("p1_c1_valid", {31'd0, val2}, 32'd0);
    chk("p1_c1_ready", {31'd0, rdy2}, 32'd0);
    step();
    chk("p1_c2_valid", {31'd0, val2}, 32'd0);
    step();
    chk("p1_c3_valid", {31'd0, val2}, 32'd1);
    chk("p1_data", dat2, W2);
    chk("p1_addr", {24'd0, adr2}, 32'h08);
    chk("p1_err",  {31'd0, err2}, 32'd0);
    step();
    chk("p1_done_valid", {31'd0, val2}, 32'd0);
    sync_idle();

    // Phase 2: LATENCY=0 streaming
    req_valid = 1'b1; req_addr = 8'h00;
    #1 chk("p2_ready0", {31'd0, rdy0}, 32'd1);
    step();
    chk("p2_v0", {31'd0, val0}, 32'd1); chk("p2_d0", dat0, W0); chk("p2_a0", {24'd0, adr0}, 32'h00);
    req_addr = 8'h04;
    #1 chk("p2_ready1", {31'd0, rdy0}, 32'd1);
    step();
    chk("p2_v1", {31'd0, val0}, 32'd1); chk("p2_d1", dat0, W1); chk("p2_a1", {24'd0, adr0}, 32'h04);
    req_addr = 8'h08;
    #1 chk("p2_ready2", {31'd0, rdy0}, 32'd1);
    step();
    chk("p2_v2", {31'd0, val0}, 32'd1); chk("p2_d2", dat0, W2); chk("p2_a2", {24'd0, adr0}, 32'h08);
    req_addr = 8'h0C;
    #1 chk("p2_ready3", {31'd0, rdy0}, 32'd1);
    step();
    chk("p2_v3", {31'd0, val0}, 32'd1); chk("p2_d3", dat0, W3); chk("p2_a3", {24'd0, adr0}, 32'h0C);
    req_valid = 1'b0;
    step();
    chk("p2_idle_valid", {31'd0, val0}, 32'd0);
    sync_idle();

    // Phase 3: misaligned fetch
    req_valid = 1'b1; req_addr = 8'h06;
    step();
    req_valid = 1'b0;
    chk("p3_valid", {31'd0, val0}, 32'd1);
    chk("p3_err",   {31'd0, err0}, 32'd1);
    chk("p3_data",  dat0, 32'd0);
    chk("p3_addr",  {24'd0, adr0}, 32'h06);
    step();
    sync_idle();

    // Phase 4: consumer stall
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 8'h04;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("p4_stall_valid", {31'd0, val0}, 32'd1);
      chk("p4_stall_data",  dat0, W1);
      chk("p4_stall_addr",  {24'd0, adr0}, 32'h04);
      chk("p4_stall_ready", {31'd0, rdy0}, 32'd0);
      step();
    end
    chk("p4_still_valid", {31'd0, val0}, 32'd1);
    resp_ready = 1'b1;
    step();
    chk("p4_done_valid", {31'd0, val0}, 32'd0);
    chk("p4_done_ready", {31'd0, rdy0}, 32'd1);
    sync_idle();

    // Phase 5: flush during WAIT, LATENCY=3
    req_valid = 1'b1; req_addr = 8'h04;
    step();
    flush = 1'b1; req_addr = 8'h0C;
    #1 chk("p5_flush_ready", {31'd0, rdy3}, 32'd0);
    step();
    flush = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("p5_no_resp", {31'd0, val3}, 32'd0);
      step();
    end
    req_valid = 1'b1; req_addr = 8'h0C;
    step();
    req_valid = 1'b0;
    chk("p5_c1_valid", {31'd0, val3}, 32'd0);
    step();
    chk("p5_c2_valid", {31'd0, val3}, 32'd0);
    step();
    chk("p5_c3_valid", {31'd0, val3}, 32'd0);
    step();
    chk("p5_c4_valid", {31'd0, val3}, 32'd1);
    chk("p5_data", dat3, W3);
    chk("p5_addr", {24'd0, adr3}, 32'h0C);
    step();
    sync_idle();

    // Phase 6a: asynchronous reset mid-WAIT
    req_valid = 1'b1; req_addr = 8'h08;
    step();
    req_valid = 1'b0;
    step();
    chk("p6a_pre_addr", {24'd0, adr3}, 32'h08);
    #2 rst = 1'b0;
    #1;
    chk("p6a_valid", {31'd0, val3}, 32'd0);
    chk("p6a_data",  dat3, 32'd0);
    chk("p6a_addr",  {24'd0, adr3}, 32'd0);
    chk("p6a_err",   {31'd0, err3}, 32'd0);
    #2 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("p6a_no_resp", {31'd0, val3}, 32'd0);
    end

    // Phase 6b: loader write on the accept edge, LATENCY=2
    req_valid = 1'b1; req_addr = 8'h08;
    ld_en = 1'b1; ld_addr = 6'd2; ld_data = WN;
    step();
    req_valid = 1'b0; ld_en = 1'b0;
    step();
    step();
    chk("p6b_old_valid", {31'd0, val2}, 32'd1);
    chk("p6b_old_data",  dat2, W2);
    step();
    sync_idle();
    req_valid = 1'b1; req_addr = 8'h08;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("p6b_new_valid", {31'd0, val2}, 32'd1);
    chk("p6b_new_data",  dat2, WN);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
